// File: rtl/motor_ramp_sequencer.sv
// Duty/direction sequencer for the HB3 PWM block: rate-limited ramping,
// brake-dead-reverse on direction change, and a level-sensitive emergency stop.
module motor_ramp_sequencer #(
    parameter int unsigned RAMP_DIV = 1000,
    parameter int unsigned DEADTIME = 5000,
    parameter int unsigned MAX_DUTY = 100
) (
    input  logic       refclk,
    input  logic       resetN,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_speed,
    input  logic       cmd_dir,
    input  logic       cmd_enable,
    input  logic       estop,
    output logic [7:0] duty_cycle,
    output logic [7:0] control,
    output logic       busy,
    output logic [2:0] state_o
);

    localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [7:0]    MAXD       = 8'(MAX_DUTY);
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEADTIME - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_HOLD  = 3'd2,
        S_BRAKE = 3'd3,
        S_DEAD  = 3'd4,
        S_ESTOP = 3'd5
    } state_t;

    state_t        r_state;
    logic [7:0]    r_duty;
    logic          r_dir;
    logic          r_run;
    logic [7:0]    r_tgt_speed;
    logic          r_tgt_dir;
    logic          r_tgt_en;
    logic [PW-1:0] r_presc;
    logic [DW-1:0] r_dead;

    logic       w_accept;
    logic       w_tick;
    logic [7:0] w_cmd_eff;
    logic [7:0] w_eff;
    logic [7:0] w_ramp_duty;
    logic [7:0] w_brake_duty;

    assign cmd_ready  = resetN && !estop && (r_state != S_ESTOP);
    assign w_accept   = cmd_valid && cmd_ready;
    assign duty_cycle = r_duty;
    assign control    = {6'b0, r_dir, r_run};
    assign busy       = (r_state != S_IDLE);
    assign state_o    = r_state;

    // Incoming command's target decides the IDLE exit; everything else steps
    // against the previously latched target.
    assign w_cmd_eff = cmd_enable ? ((cmd_speed > MAXD) ? MAXD : cmd_speed) : '0;
    assign w_eff     = r_tgt_en ? ((r_tgt_speed > MAXD) ? MAXD : r_tgt_speed) : '0;
    assign w_tick    = (r_presc == PRESC_LAST);

    always_comb begin
        w_ramp_duty = r_duty;
        if (w_tick) begin
            if (r_duty < w_eff)
                w_ramp_duty = r_duty + 8'd1;
            else if (r_duty > w_eff)
                w_ramp_duty = r_duty - 8'd1;
        end
    end

    assign w_brake_duty = (w_tick && (r_duty != '0)) ? r_duty - 8'd1 : r_duty;

    always_ff @(posedge refclk) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_duty      <= '0;
            r_dir       <= 1'b0;
            r_run       <= 1'b0;
            r_tgt_speed <= '0;
            r_tgt_dir   <= 1'b0;
            r_tgt_en    <= 1'b0;
            r_presc     <= '0;
            r_dead      <= '0;
        end else if (estop) begin
            r_state <= S_ESTOP;
            r_duty  <= '0;
            r_dir   <= 1'b0;
            r_run   <= 1'b0;
            r_presc <= '0;
            r_dead  <= '0;
        end else begin
            if (w_accept) begin
                r_tgt_speed <= cmd_speed;
                r_tgt_dir   <= cmd_dir;
                r_tgt_en    <= cmd_enable;
            end
            case (r_state)
                S_IDLE: begin
                    r_duty <= '0;
                    r_run  <= 1'b0;
                    if (w_accept && (w_cmd_eff != '0)) begin
                        r_presc <= '0;
                        r_dead  <= '0;
                        if (cmd_dir == r_dir) begin
                            r_state <= S_RAMP;
                            r_run   <= 1'b1;
                        end else begin
                            r_state <= S_DEAD;
                        end
                    end
                end
                S_RAMP: begin
                    if ((r_tgt_dir != r_dir) && r_run) begin
                        r_state <= S_BRAKE;
                        r_presc <= '0;
                    end else begin
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
                        r_duty  <= w_ramp_duty;
                        if (w_ramp_duty == w_eff) begin
                            if (w_eff == '0) begin
                                r_state <= S_IDLE;
                                r_run   <= 1'b0;
                            end else begin
                                r_state <= S_HOLD;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (r_tgt_dir != r_dir) begin
                        r_state <= S_BRAKE;
                        r_presc <= '0;
                    end else if (w_eff != r_duty) begin
                        r_state <= S_RAMP;
                        r_presc <= '0;
                    end
                end
                S_BRAKE: begin
                    r_presc <= w_tick ? '0 : r_presc + 1'b1;
                    r_duty  <= w_brake_duty;
                    if (w_brake_duty == '0) begin
                        r_state <= S_DEAD;
                        r_run   <= 1'b0;
                        r_dead  <= '0;
                    end
                end
                S_DEAD: begin
                    r_duty <= '0;
                    r_run  <= 1'b0;
                    if (r_dead == DEAD_LAST) begin
                        r_dead <= '0;
                        r_dir  <= r_tgt_dir;
                        if (w_eff != '0) begin
                            r_state <= S_RAMP;
                            r_run   <= 1'b1;
                            r_presc <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_dead <= r_dead + 1'b1;
                    end
                end
                S_ESTOP: begin
                    r_state  <= S_IDLE;
                    r_tgt_en <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Bench for motor_ramp_sequencer: directed scenarios plus random commands,
// checked cycle by cycle against a countdown-based behavioural model.
module tb_motor_ramp_sequencer;

    localparam int RD = 4;
    localparam int DT = 8;
    localparam int MD = 100;

    logic       refclk = 1'b0;
    logic       resetN = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_speed = '0;
    logic       cmd_dir = 1'b0;
    logic       cmd_enable = 1'b0;
    logic       estop = 1'b0;
    logic       cmd_ready;
    logic [7:0] duty_cycle;
    logic [7:0] control;
    logic       busy;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    // Model: state numbers as listed in the port description; m_cd counts
    // cycles remaining to the next duty step, m_dl cycles remaining of dead time.
    int m_state, m_duty, m_dir, m_run, t_speed, t_dir, t_en, m_cd, m_dl;

    always #5 refclk = ~refclk;

    motor_ramp_sequencer #(
        .RAMP_DIV(RD),
        .DEADTIME(DT),
        .MAX_DUTY(MD)
    ) dut (
        .refclk    (refclk),
        .resetN    (resetN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_speed (cmd_speed),
        .cmd_dir   (cmd_dir),
        .cmd_enable(cmd_enable),
        .estop     (estop),
        .duty_cycle(duty_cycle),
        .control   (control),
        .busy      (busy),
        .state_o   (state_o)
    );

    function automatic int eff_of(input int en, input int sp);
        if (en == 0) return 0;
        return (sp > MD) ? MD : sp;
    endfunction

    task automatic model_edge();
        int eff_old, ceff, old_tdir;
        bit acc;
        if (!resetN) begin
            m_state = 0; m_duty = 0; m_dir = 0; m_run = 0;
            t_speed = 0; t_dir = 0; t_en = 0; m_cd = RD; m_dl = DT;
            return;
        end
        if (estop) begin
            m_state = 5; m_duty = 0; m_run = 0; m_dir = 0; m_cd = RD;
            return;
        end
        acc      = cmd_valid && (m_state != 5);
        eff_old  = eff_of(t_en, t_speed);
        old_tdir = t_dir;
        ceff     = eff_of(int'(cmd_enable), int'(cmd_speed));
        if (acc) begin
            t_speed = cmd_speed; t_dir = cmd_dir; t_en = cmd_enable;
        end
        case (m_state)
            0: if (acc && ceff > 0) begin
                if (int'(cmd_dir) == m_dir) begin
                    m_state = 1; m_run = 1; m_cd = RD;
                end else begin
                    m_state = 4; m_dl = DT;
                end
            end
            1: if (old_tdir != m_dir && m_run == 1) begin
                m_state = 3; m_cd = RD;
            end else begin
                if (m_cd == 1) begin
                    m_cd = RD;
                    if (m_duty < eff_old) m_duty++;
                    else if (m_duty > eff_old) m_duty--;
                end else m_cd--;
                if (m_duty == eff_old) begin
                    if (eff_old == 0) begin m_state = 0; m_run = 0; end
                    else m_state = 2;
                end
            end
            2: if (old_tdir != m_dir) begin
                m_state = 3; m_cd = RD;
            end else if (eff_old != m_duty) begin
                m_state = 1; m_cd = RD;
            end
            3: begin
                if (m_cd == 1) begin
                    m_cd = RD;
                    if (m_duty > 0) m_duty--;
                end else m_cd--;
                if (m_duty == 0) begin m_state = 4; m_run = 0; m_dl = DT; end
            end
            4: if (m_dl == 1) begin
                m_dir = old_tdir;
                if (eff_old > 0) begin m_state = 1; m_run = 1; m_cd = RD; end
                else m_state = 0;
            end else m_dl--;
            5: begin m_state = 0; t_en = 0; end
            default: m_state = 0;
        endcase
    endtask

    function automatic logic [20:0] dv();
        return {duty_cycle, control, state_o, busy, cmd_ready};
    endfunction

    function automatic logic [20:0] mv();
        logic rdy;
        rdy = resetN && !estop && (m_state != 5);
        return {8'(m_duty), 6'b0, 1'(m_dir), 1'(m_run), 3'(m_state), (m_state != 0), rdy};
    endfunction

    task automatic tick();
        @(posedge refclk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        tick();
        tick();
        checks++;
        if (dv() !== 21'h0) begin
            errors++; $display("FAIL reset_outputs dut=%h required=0", dv());
        end
        resetN = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || dv() !== mv()) begin
            errors++; $display("FAIL reset_release dut=%h model=%h", dv(), mv());
        end
    endtask

    task automatic test_ramp_up();
        cmd_valid = 1; cmd_speed = 10; cmd_dir = 0; cmd_enable = 1;
        tick();
        cmd_valid = 0;
        checks++;
        if (control !== 8'h01 || state_o !== 3'd1) begin
            errors++; $display("FAIL ramp_start control=%h state=%0d required 01/1", control, state_o);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (dv() !== mv()) begin
                errors++; $display("FAIL ramp_up cyc%0d dut=%h model=%h", i, dv(), mv());
            end
            if (i == 2 || i == 3) begin
                checks++;
                if (duty_cycle !== 8'(i - 2)) begin
                    errors++; $display("FAIL first_step cyc%0d duty=%0d required %0d", i, duty_cycle, i - 2);
                end
            end
        end
        checks++;
        if (duty_cycle !== 8'd10 || state_o !== 3'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL ramp_done duty=%0d state=%0d busy=%b required 10/2/1", duty_cycle, state_o, busy);
        end
    endtask

    task automatic test_disable();
        cmd_valid = 1; cmd_speed = 5; cmd_dir = 0; cmd_enable = 1;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (dv() !== mv()) begin
                errors++; $display("FAIL ramp_down5 cyc%0d dut=%h model=%h", i, dv(), mv());
            end
        end
        checks++;
        if (duty_cycle !== 8'd5 || state_o !== 3'd2) begin
            errors++; $display("FAIL hold5 duty=%0d state=%0d required 5/2", duty_cycle, state_o);
        end
        cmd_valid = 1; cmd_enable = 0;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (dv() !== mv()) begin
                errors++; $display("FAIL disable cyc%0d dut=%h model=%h", i, dv(), mv());
            end
            if (duty_cycle == 8'd0) break;
        end
        checks++;
        if (duty_cycle !== 8'd0 || state_o !== 3'd0 || control !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL disable_idle duty=%0d state=%0d control=%h busy=%b required 0/0/00/0",
                               duty_cycle, state_o, control, busy);
        end
    endtask

    task automatic test_estop();
        bit seen7 = 0;
        cmd_valid = 1; cmd_speed = 20; cmd_dir = 0; cmd_enable = 1;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 100 && !seen7; i++) begin
            tick();
            checks++;
            if (dv() !== mv()) begin
                errors++; $display("FAIL estop_ramp cyc%0d dut=%h model=%h", i, dv(), mv());
            end
            if (duty_cycle == 8'd7) seen7 = 1;
        end
        checks++;
        if (!seen7) begin
            errors++; $display("FAIL estop_reach7 duty=%0d required 7 within 100 cycles", duty_cycle);
        end
        estop = 1; cmd_valid = 1; cmd_speed = 50; cmd_enable = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (duty_cycle !== 8'd0 || control !== 8'h00 || state_o !== 3'd5 || cmd_ready !== 1'b0
                || dv() !== mv()) begin
                errors++; $display("FAIL estop_hold cyc%0d dut=%h model=%h", i, dv(), mv());
            end
        end
        estop = 0;
        tick();
        cmd_valid = 0;
        checks++;
        if (state_o !== 3'd0 || duty_cycle !== 8'd0 || dv() !== mv()) begin
            errors++; $display("FAIL estop_release dut=%h model=%h", dv(), mv());
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (duty_cycle !== 8'd0 || state_o !== 3'd0 || dv() !== mv()) begin
                errors++; $display("FAIL estop_no_motion cyc%0d dut=%h model=%h", i, dv(), mv());
            end
        end
    endtask

    task automatic test_reverse();
        int dead_cycles = 0;
        bit ctl_zero = 0;
        cmd_valid = 1; cmd_speed = 10; cmd_dir = 0; cmd_enable = 1;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 41; i++) begin
            tick();
            checks++;
            if (dv() !== mv()) begin
                errors++; $display("FAIL rev_pre cyc%0d dut=%h model=%h", i, dv(), mv());
            end
        end
        checks++;
        if (duty_cycle !== 8'd10 || state_o !== 3'd2) begin
            errors++; $display("FAIL rev_hold10 duty=%0d state=%0d required 10/2", duty_cycle, state_o);
        end
        cmd_valid = 1; cmd_dir = 1;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (dv() !== mv()) begin
                errors++; $display("FAIL reverse cyc%0d dut=%h model=%h", i, dv(), mv());
            end
            if (state_o == 3'd4) begin
                dead_cycles++;
                if (control == 8'h00 && duty_cycle == 8'd0) ctl_zero = 1;
            end
        end
        checks++;
        if (dead_cycles != DT || !ctl_zero) begin
            errors++; $display("FAIL dead_time cycles=%0d ctl_zero=%b required %0d/1", dead_cycles, ctl_zero, DT);
        end
        checks++;
        if (duty_cycle !== 8'd10 || control !== 8'h03 || state_o !== 3'd2) begin
            errors++; $display("FAIL rev_done duty=%0d control=%h state=%0d required 10/03/2",
                               duty_cycle, control, state_o);
        end
    endtask

    task automatic test_clamp();
        int max_duty = 0;
        cmd_valid = 1; cmd_speed = 200; cmd_dir = 1; cmd_enable = 1;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            checks++;
            if (dv() !== mv()) begin
                errors++; $display("FAIL clamp cyc%0d dut=%h model=%h", i, dv(), mv());
            end
            if (int'(duty_cycle) > max_duty) max_duty = duty_cycle;
        end
        checks++;
        if (max_duty != MD || duty_cycle !== 8'd100 || state_o !== 3'd2) begin
            errors++; $display("FAIL clamp_sat max=%0d duty=%0d state=%0d required 100/100/2",
                               max_duty, duty_cycle, state_o);
        end
    endtask

    task automatic test_reset_mid_brake();
        cmd_valid = 1; cmd_dir = 0;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (state_o !== 3'd3 || dv() !== mv()) begin
            errors++; $display("FAIL brake_before_reset dut=%h model=%h", dv(), mv());
        end
        resetN = 0;
        tick();
        checks++;
        if (dv() !== 21'h0) begin
            errors++; $display("FAIL reset_mid_brake dut=%h required=0", dv());
        end
        resetN = 1;
        cmd_valid = 1; cmd_speed = 3; cmd_dir = 0; cmd_enable = 1;
        tick();
        cmd_valid = 0;
        checks++;
        if (control !== 8'h01 || state_o !== 3'd1) begin
            errors++; $display("FAIL restart control=%h state=%0d required 01/1", control, state_o);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (dv() !== mv()) begin
                errors++; $display("FAIL restart_ramp cyc%0d dut=%h model=%h", i, dv(), mv());
            end
        end
        checks++;
        if (duty_cycle !== 8'd3 || state_o !== 3'd2) begin
            errors++; $display("FAIL restart_done duty=%0d state=%0d required 3/2", duty_cycle, state_o);
        end
    endtask

    task automatic test_random();
        int estop_left = 0;
        for (int i = 0; i < 3000; i++) begin
            cmd_valid  = ($urandom_range(0, 39) == 0);
            cmd_speed  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            cmd_dir    = 1'($urandom_range(0, 1));
            cmd_enable = ($urandom_range(0, 3) != 0);
            if (estop_left > 0) estop_left--;
            else if ($urandom_range(0, 499) == 0) estop_left = $urandom_range(1, 4);
            estop  = (estop_left > 0);
            resetN = ($urandom_range(0, 1499) != 0);
            tick();
            checks++;
            if (dv() !== mv()) begin
                errors++; $display("FAIL random cyc%0d dut=%h model=%h", i, dv(), mv());
            end
        end
        cmd_valid = 0; estop = 0; resetN = 1;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_disable();
        test_estop();
        test_reverse();
        test_clamp();
        test_reset_mid_brake();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
